// File: rtl/ex_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ex_muldiv                                                  |
// | Purpose : EX-stage multiply/divide unit owning the HI/LO registers.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ex_muldiv #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall_ex,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             stallreq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int                  c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
    localparam logic [2:0]         c_op_mthi = 3'b100;
    localparam logic [2:0]         c_op_mtlo = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_src1;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_is_div;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic                 r_div0;

    logic                 w_is_md;
    logic                 w_is_mt;
    logic                 w_neg1;
    logic                 w_neg2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic                 w_accept;
    logic                 w_mt_wr;
    logic                 w_fast;
    logic                 w_last;
    logic                 w_stallreq;
    logic [2*WIDTH-1:0]   w_fast_prod;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_div_sh;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_sub;
    logic [WIDTH-1:0]     w_div_rem;
    logic [2*WIDTH-1:0]   w_div_nxt;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // Op decode: codes 000..011 are muldiv, even codes among them are signed.
    assign w_is_md  = ~op[2];
    assign w_is_mt  = (op == c_op_mthi) || (op == c_op_mtlo);
    assign w_neg1   = ~op[0] & src1[WIDTH-1];
    assign w_neg2   = ~op[0] & src2[WIDTH-1];
    assign w_mag1   = w_neg1 ? -src1 : src1;
    assign w_mag2   = w_neg2 ? -src2 : src2;
    assign w_accept = (r_state == S_IDLE) & op_valid & w_is_md & ~flush;
    assign w_mt_wr  = (r_state == S_IDLE) & op_valid & w_is_mt & ~flush;
    assign w_fast   = FAST_MUL && !op[1];
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_last);

    generate
        if (FAST_MUL) begin : g_fast_mul
            logic [2*WIDTH-1:0] w_p;
            assign w_p         = {{WIDTH{1'b0}}, w_mag1} * {{WIDTH{1'b0}}, w_mag2};
            assign w_fast_prod = (w_neg1 ^ w_neg2) ? -w_p : w_p;
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    // Shift-add: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}, one bit per cycle.
    assign w_div_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge  = w_div_sh >= {1'b0, r_b};
    assign w_div_sub = w_div_sh[WIDTH-1:0] - r_b;
    assign w_div_rem = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
    assign w_div_nxt = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

    assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
    assign w_prod    = r_neg_res ? -w_acc_nxt : w_acc_nxt;
    assign w_quo     = r_neg_res ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    assign w_rem     = r_neg_rem ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_res_hi = r_src1;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stallreq  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stallreq  = 1'b1;
                    w_state_nxt = w_fast ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_stallreq = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!stall_ex) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_src1    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_acc     <= {{WIDTH{1'b0}}, w_mag1};
                r_b       <= w_mag2;
                r_src1    <= src1;
                r_is_div  <= op[1];
                r_neg_res <= w_neg1 ^ w_neg2;
                r_neg_rem <= w_neg1;
                r_div0    <= (src2 == '0);
                r_cnt     <= '0;
                if (w_fast) begin
                    r_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_fast_prod[WIDTH-1:0];
                end
            end else if ((r_state == S_RUN) && !flush) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + c_one;
                if (w_last) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end
            if (w_mt_wr) begin
                if (op[0]) r_lo <= src1;
                else       r_hi <= src1;
            end
        end
    end

    assign stallreq = w_stallreq;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ex_muldiv                                               |
// | Purpose : Self-checking bench for ex_muldiv, iterative and fast mul. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ex_muldiv;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, flush, stall_ex, op_valid, sel_f;
    logic [2:0]    op;
    logic [W-1:0]  src1, src2;
    logic          ov_s, ov_f;
    logic          stallreq_s, busy_s, done_s, stallreq_f, busy_f, done_f;
    logic [W-1:0]  hi_s, lo_s, hi_f, lo_f;
    logic          m_stallreq, m_busy, m_done;
    logic [W-1:0]  m_hi, m_lo;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // sel_f steers op_valid to one unit and selects whose outputs are observed.
    assign ov_s       = op_valid & ~sel_f;
    assign ov_f       = op_valid & sel_f;
    assign m_stallreq = sel_f ? stallreq_f : stallreq_s;
    assign m_busy     = sel_f ? busy_f : busy_s;
    assign m_done     = sel_f ? done_f : done_s;
    assign m_hi       = sel_f ? hi_f : hi_s;
    assign m_lo       = sel_f ? lo_f : lo_s;

    ex_muldiv #(.WIDTH(W), .FAST_MUL(1'b0)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex),
        .op_valid(ov_s), .op(op), .src1(src1), .src2(src2),
        .stallreq(stallreq_s), .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s)
    );

    ex_muldiv #(.WIDTH(W), .FAST_MUL(1'b1)) dut_f (
        .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex),
        .op_valid(ov_f), .op(op), .src1(src1), .src2(src2),
        .stallreq(stallreq_f), .busy(busy_f), .done(done_f), .hi(hi_f), .lo(lo_f)
    );

    typedef struct {
        logic        f;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        vt[10];
    logic [31:0] mh[2];
    logic [31:0] ml[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
    function automatic void ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = '0;
        l  = '0;
        case (o)
            3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd1: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
            3'd2: begin
                if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
            end
            default: begin
                if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                else begin h = a % b; l = a / b; end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic run_op(input string nm, input logic f, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int ns;
        @(posedge clk); #1;
        sel_f = f; op_valid = 1'b1; op = o; src1 = a; src2 = b;
        ns = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!m_stallreq) break;
            ns++;
        end
        chk({nm, " stall_cycles"}, 64'(ns), (f && o[1] == 1'b0) ? 64'd1 : 64'(W + 1));
        chk({nm, " done"}, {m_done, m_busy}, 2'b11);
        chk({nm, " hi"}, m_hi, eh);
        chk({nm, " lo"}, m_lo, el);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk({nm, " done_pulse"}, {m_done, m_busy, m_stallreq}, 3'b000);
    endtask

    task automatic mt_op(input string nm, input logic f, input logic [2:0] o, input logic [31:0] v,
                         input logic [31:0] eh, input logic [31:0] el);
        @(posedge clk); #1;
        sel_f = f; op_valid = 1'b1; op = o; src1 = v; src2 = ~v;
        @(negedge clk);
        chk({nm, " nostall"}, {m_stallreq, m_busy}, 2'b00);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk({nm, " hi"}, m_hi, eh);
        chk({nm, " lo"}, m_lo, el);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ns;
        logic [31:0] eh, el, a, b;
        logic [2:0]  o;
        logic        f;

        vt[0] = '{1'b0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[1] = '{1'b0, 3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[2] = '{1'b1, 3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[3] = '{1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[4] = '{1'b0, 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[5] = '{1'b0, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[6] = '{1'b0, 3'd3, 32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF};
        vt[7] = '{1'b0, 3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vt[8] = '{1'b0, 3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vt[9] = '{1'b0, 3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; op_valid = 1'b0; sel_f = 1'b0;
        op = 3'd0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_s flags", {m_stallreq, m_busy, m_done}, 3'b000);
        chk("reset_s hilo", {m_hi, m_lo}, 64'd0);
        sel_f = 1'b1; #1;
        chk("reset_f flags", {m_stallreq, m_busy, m_done}, 3'b000);
        chk("reset_f hilo", {m_hi, m_lo}, 64'd0);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vt[i].f, vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);

        // Flush mid-divide with HI/LO preloaded; flush held also blocks re-acceptance.
        mt_op("mthi", 1'b0, 3'b100, 32'h11, 32'h11, vt[9].lo);
        mt_op("mtlo", 1'b0, 3'b101, 32'h22, 32'h11, 32'h22);
        @(posedge clk); #1;
        sel_f = 1'b0; op_valid = 1'b1; op = 3'd3; src1 = 32'd100; src2 = 32'd3;
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush run_state", {m_busy, m_stallreq}, 2'b11);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush idle", {m_busy, m_stallreq, m_done}, 3'b000);
        chk("flush hilo", {m_hi, m_lo}, {32'h11, 32'h22});
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        chk("flush no_accept", {m_busy, m_hi, m_lo}, {1'b0, 32'h11, 32'h22});

        // DONE hold under stall_ex with the instruction still presented.
        @(posedge clk); #1;
        op_valid = 1'b1; op = 3'd1; src1 = 32'd3; src2 = 32'd4; stall_ex = 1'b1;
        ns = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!m_stallreq) break;
            ns++;
        end
        chk("hold stall_cycles", 64'(ns), 64'(W + 1));
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            chk($sformatf("hold done%0d", j), {m_done, m_stallreq, m_busy}, 3'b101);
        end
        @(posedge clk); #1;
        stall_ex = 1'b0;
        @(negedge clk);
        chk("hold release_cycle", {m_done, m_stallreq}, 2'b10);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("hold idle", {m_done, m_busy, m_stallreq}, 3'b000);
        chk("hold hilo", {m_hi, m_lo}, {32'd0, 32'd12});

        // Synchronous reset in the middle of an iterative multiply.
        mt_op("mthi2", 1'b0, 3'b100, 32'h55, 32'h55, 32'd12);
        @(posedge clk); #1;
        op_valid = 1'b1; op = 3'd1; src1 = 32'd7; src2 = 32'd9;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst pre busy", m_busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        chk("rst mid_run", {m_hi, m_lo, m_busy, m_stallreq}, 66'd0);
        sel_f = 1'b1; #1;
        chk("rst fast hilo", {m_hi, m_lo}, 64'd0);

        mh[0] = '0; ml[0] = '0; mh[1] = '0; ml[1] = '0;
        for (int k = 0; k < 40; k++) begin
            f = k[0];
            o = 3'($urandom_range(0, 5));
            a = pick();
            b = pick();
            if (o[2] == 1'b0) begin
                ref_md(o, a, b, eh, el);
                mh[f] = eh; ml[f] = el;
                run_op($sformatf("rnd%0d op%0d %h %h", k, o, a, b), f, o, a, b, eh, el);
            end else begin
                if (o[0]) ml[f] = a;
                else      mh[f] = a;
                mt_op($sformatf("rnd%0d op%0d %h", k, o, a), f, o, a, mh[f], ml[f]);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
